// File: rtl/uart_rx_engine_if.sv
// uart_rx_engine_if
// Receive-side handshake between the UART receive engine and its consumer.
//   rx_data  : head-of-FIFO data word, first received bit in the LSB
//   rx_perr  : parity error flag of the head entry
//   rx_ferr  : framing error flag of the head entry
//   rx_valid : FIFO holds at least one entry
//   rx_ready : consumer accepts the head entry when rx_valid is also high
// master = receive engine (producer), slave = register/APB side (consumer).
interface uart_rx_engine_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data, rx_perr, rx_ferr, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_perr, rx_ferr, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_engine.sv
// uart_rx_engine
// Oversampling UART receiver: synchronizes RX, finds the start bit, samples
// each bit at its middle, checks optional parity and the stop bit, and
// queues {ferr, perr, data} in a small first-word-fall-through FIFO.
// Ports:
//   PCLK       : the only clock, rising edge
//   PRESETn    : synchronous reset, active HIGH despite its name
//   RX         : asynchronous serial line, idles high
//   rx_if      : master side of the receive handshake (data/flags/valid/ready)
//   rx_overrun : one-cycle pulse when a finished frame is dropped (FIFO full)
//   rx_busy    : receiver is inside a frame (FSM not idle)
module uart_rx_engine #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              RX,
  uart_rx_engine_if.master  rx_if,
  output logic              rx_overrun,
  output logic              rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Two-flop synchronizer; both stages reload to the idle level on reset.
  logic r_rx_s1, r_rx_s2;

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
    end
  end

  state_t                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;
  logic [IDX_W-1:0]       r_bit_idx, w_bit_idx_next;
  logic [DATA_BITS-1:0]   r_shift, w_shift_next;
  logic                   r_perr, w_perr_next;
  logic                   w_push;
  logic                   w_ferr;
  logic                   w_bit_end;

  assign w_bit_end = (r_cnt == BIT_M1);

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_perr    <= w_perr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_perr_next    = r_perr;
    w_push         = 1'b0;
    w_ferr         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s2) begin
          w_state_next = S_START;
          w_cnt_next   = '0;
          w_perr_next  = 1'b0;
        end
      end
      S_START: begin
        // Re-check the line half a bit in; a high here was only a glitch.
        if (r_cnt == HALF_M1) begin
          w_cnt_next = '0;
          if (!r_rx_s2) begin
            w_state_next   = S_DATA;
            w_bit_idx_next = '0;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_next              = '0;
          w_shift_next[r_bit_idx] = r_rx_s2;
          if (r_bit_idx == LAST_IDX) begin
            w_bit_idx_next = '0;
            w_state_next   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_perr_next  = ((^r_shift) ^ r_rx_s2) != PAR_ODD;
          w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        // Leaving mid-stop-bit lets a following start bit be caught with no gap.
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_push       = 1'b1;
          w_ferr       = ~r_rx_s2;
          w_state_next = r_rx_s2 ? S_IDLE : S_WAIT_HIGH;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must return high before a new frame starts.
        if (r_rx_s2) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign rx_busy = (r_state != S_IDLE);

  // Receive FIFO, first word fall through.
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overrun;
  logic             w_full, w_wr_en, w_rd_en, w_valid;
  logic [ENT_W-1:0] w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_valid = (r_count != '0);
  // Full is judged on the pre-pop count, so a simultaneous pop does not save the frame.
  assign w_wr_en = w_push & ~w_full;
  assign w_rd_en = rx_if.rx_ready & w_valid;

  always_ff @(posedge PCLK) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {w_ferr, r_perr, r_shift};
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push & w_full;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + {{PTR_W{1'b0}}, w_wr_en} - {{PTR_W{1'b0}}, w_rd_en};
    end
  end

  // Outputs read as zero while empty, which also covers stale storage after reset.
  assign w_head         = w_valid ? r_mem[r_rd_ptr] : '0;
  assign rx_if.rx_data  = w_head[DATA_BITS-1:0];
  assign rx_if.rx_perr  = w_head[DATA_BITS];
  assign rx_if.rx_ferr  = w_head[DATA_BITS+1];
  assign rx_if.rx_valid = w_valid;
  assign rx_overrun     = r_overrun;

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Serial receive engine for the UART peripheral. It accepts the asynchronous `RX` line, detects start bits, and samples each bit at mid-bit using a fixed clock divisor. It checks optional parity and the stop bit, then buffers received frames in a small first-word-fall-through FIFO for the register/APB side. It sits between the UART pad input and the receive-data register path, and pairs with the existing transmit path that drives `Tx`.

## Interface
- `CLKS_PER_BIT`, default 16: PCLK cycles per bit. Must be even and ≥ 4.
- `DATA_BITS`, default 8: data bits per frame. Legal range 5–8.
- `PARITY_EN`, default 0: 1 adds a parity bit after the data bits.
- `PARITY_ODD`, default 0: 1 selects odd parity, 0 selects even. Ignored when `PARITY_EN`=0.
- `FIFO_DEPTH`, default 4: receive FIFO entries. Power of two, ≥ 2.
- `PCLK`, input, 1: the only clock. All logic is on the rising edge.
- `PRESETn`, input, 1: **synchronous, active-high reset**. Asserted when 1, sampled on `PCLK`.
- `RX`, input, 1: asynchronous serial line. Idles high.
- `rx_data`, output, `DATA_BITS`: data of the FIFO head entry. The first received bit is the LSB.
- `rx_perr`, output, 1: parity error flag of the head entry.
- `rx_ferr`, output, 1: framing error (stop bit = 0) flag of the head entry.
- `rx_valid`, output, 1: FIFO is non-empty.
- `rx_ready`, input, 1: consumer pops the head entry when `rx_valid && rx_ready`.
- `rx_overrun`, output, 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.
- `rx_busy`, output, 1: FSM is not in IDLE.

## Operation
- **Synchronizer:** `RX` passes through two flops, `rx_s1` then `rx_s2`. Both reset to 1. The FSM uses only `rx_s2`.
- **IDLE:** if `rx_s2`=0, go to START with `cnt`=0.
- **START:** `cnt` increments each cycle. At `cnt`=`CLKS_PER_BIT`/2−1, sample `rx_s2`:
  - 0: go to DATA with `cnt`=0 and `bit_idx`=0.
  - 1: glitch; go back to IDLE. Nothing is pushed.
- **DATA:** at `cnt`=`CLKS_PER_BIT`−1, sample `rx_s2` into `shift[bit_idx]` and reset `cnt`. After bit `DATA_BITS`−1 is sampled, go to PARITY if `PARITY_EN`=1, otherwise STOP.
- **PARITY:** sample at `cnt`=`CLKS_PER_BIT`−1.
  - `perr` = (XOR of data bits ^ sampled bit) != `PARITY_ODD`.
  - Then go to STOP.
- **STOP:** sample at `cnt`=`CLKS_PER_BIT`−1. `ferr` = ~sample. Push {`ferr`, `perr`, `shift`} into the FIFO, or pulse `rx_overrun` if the FIFO is full. Then:
  - if `ferr`=0, go to IDLE;
  - if `ferr`=1, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s2`=1, then go to IDLE. This prevents a break condition from retriggering frames.
- **FIFO:** read and write pointers plus a count of width log2(`FIFO_DEPTH`)+1.
  - Push and pop in the same cycle is legal when the FIFO is non-empty; the count is unchanged.
  - When the FIFO is full, a push is dropped even if a pop happens in the same cycle. Overrun is decided on the pre-pop count.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A pop while `rx_valid`=0 is ignored.
- **Reset values:**
  - State IDLE, `cnt`=0, `bit_idx`=0.
  - FIFO empty; `rx_valid`=0, `rx_overrun`=0, `rx_busy`=0.
  - `rx_data`=0, `rx_perr`=0, `rx_ferr`=0.
- **Reset mid-frame:** the partial frame is discarded, the FIFO is cleared, and the synchronizer is reloaded with 1.

## Timing
- Let T be the first `PCLK` edge at which the FSM sees `rx_s2`=0 in IDLE. `RX` falls before edge T−2.
- START sample occurs at edge T+`CLKS_PER_BIT`/2.
- Data bit i is sampled at edge T+`CLKS_PER_BIT`/2+(i+1)·`CLKS_PER_BIT`.
- The STOP sample and FIFO write occur at edge T+`CLKS_PER_BIT`/2+(`DATA_BITS`+`PARITY_EN`+1)·`CLKS_PER_BIT`.
- `rx_valid` rises in the cycle after the write when the FIFO was empty.
- Default parameters: STOP sample at T+152; `rx_valid` high from T+153.
- `rx_overrun` is high for exactly the one cycle after the dropped write.
- After a good stop bit, IDLE is re-entered mid-stop-bit, so back-to-back frames with no idle gap are received.
- `rx_data`, `rx_perr` and `rx_ferr` are stable while `rx_valid`=1 and `rx_ready`=0.

## Test plan
- **Basic 8N1:** defaults, send 0xA5 then 0x3C back-to-back, `rx_ready`=1 → two entries, 0xA5 then 0x3C. `perr`=0, `ferr`=0, `rx_valid` first high at T+153.
- **Glitch rejection:** `RX` low for 5 cycles, then high → FSM returns to IDLE, `rx_valid` stays 0, `rx_busy` pulses for ≤ 8 cycles.
- **Parity:** `PARITY_EN`=1, `PARITY_ODD`=0.
  - Send 0x07 with parity bit 1 → `rx_perr`=0.
  - Send 0x07 with parity bit 0 → `rx_perr`=1, `rx_data`=0x07.
- **Framing/break:** hold `RX` low for 20 bit times → one entry with `rx_data`=0x00 and `rx_ferr`=1. No further entries until `RX` returns high and a new start bit arrives.
- **Overrun:** `rx_ready`=0, send 5 frames 0x01–0x05 → FIFO holds 0x01–0x04 and `rx_overrun` pulses once on frame 5. Then `rx_ready`=1 drains exactly 4 entries in order.
- **Reset mid-frame:** assert `PRESETn` for 1 cycle during data bit 3 → `rx_busy`=0 and `rx_valid`=0 next cycle. The following clean frame 0x5A is received correctly.
